// File: rtl/prince_op_sequencer_if.sv
// Host handshake and datapath control bundle for the PRINCE operation sequencer.
// master: host/datapath side; slave: the sequencer that drives all controls.
interface prince_op_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       load_sel;
    logic       state_en;
    logic       rnd_en;
    logic [3:0] round;
    logic [3:0] stage;
    logic       mid_sel;
    logic       inv_sel;
    logic       last_sel;
    logic       busy;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  load_sel,
        input  state_en,
        input  rnd_en,
        input  round,
        input  stage,
        input  mid_sel,
        input  inv_sel,
        input  last_sel,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output load_sel,
        output state_en,
        output rnd_en,
        output round,
        output stage,
        output mid_sel,
        output inv_sel,
        output last_sel,
        output busy
    );
endinterface

// File: rtl/prince_op_sequencer.sv
// Operation sequencer for the masked, pipelined-S-box PRINCE round datapath.
// Walks the 11-round schedule (middle round twice as long) and freezes the result until consumed.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// LOAD  | one cycle, datapath loads whitened input
// RUN   | rounds 1..11 with per-round S-box stages, PRNG advancing
// HOLD  | result frozen, out_valid=1 until out_ready
module prince_op_sequencer #(
    parameter int SBOX_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    prince_op_sequencer_if.slave  bus
);

    if (SBOX_STAGES < 1 || SBOX_STAGES > 8) begin : g_bad_stages
        $error("prince_op_sequencer: SBOX_STAGES must be in 1..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] STG_LAST     = 4'(SBOX_STAGES - 1);
    localparam logic [3:0] STG_MID_LAST = 4'(2 * SBOX_STAGES - 1);
    localparam logic [3:0] STG_HALF     = 4'(SBOX_STAGES);
    localparam logic [3:0] RND_MID      = 4'd6;
    localparam logic [3:0] RND_LAST     = 4'd11;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] stage_q, stage_d;

    logic in_run;
    logic rnd_last_stg;
    logic op_last;

    always_comb begin
        in_run       = (state_q == ST_RUN);
        rnd_last_stg = (round_q == RND_MID) ? (stage_q == STG_MID_LAST)
                                            : (stage_q == STG_LAST);
        op_last      = in_run && (round_q == RND_LAST) && (stage_q == STG_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            round_q <= 4'd0;
            stage_q <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            stage_q <= stage_d;
        end
    end

    // round/stage are held at zero outside RUN so the outputs need no extra gating
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        stage_d = stage_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_LOAD;
                    round_d = 4'd0;
                    stage_d = 4'd0;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                round_d = 4'd1;
                stage_d = 4'd0;
            end
            ST_RUN: begin
                if (op_last) begin
                    state_d = ST_HOLD;
                    round_d = 4'd0;
                    stage_d = 4'd0;
                end else if (rnd_last_stg) begin
                    round_d = round_q + 4'd1;
                    stage_d = 4'd0;
                end else begin
                    stage_d = stage_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = bus.in_valid ? ST_LOAD : ST_IDLE;
                    round_d = 4'd0;
                    stage_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 4'd0;
                stage_d = 4'd0;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.load_sel  = (state_q == ST_LOAD);
    assign bus.state_en  = (state_q == ST_LOAD) || in_run;
    assign bus.rnd_en    = in_run;
    assign bus.busy      = (state_q == ST_LOAD) || in_run;
    assign bus.round     = round_q;
    assign bus.stage     = stage_q;
    assign bus.mid_sel   = in_run && (round_q == RND_MID);
    assign bus.inv_sel   = in_run && ((round_q > RND_MID) ||
                                      ((round_q == RND_MID) && (stage_q >= STG_HALF)));
    assign bus.last_sel  = op_last;

endmodule

// File: tb/tb_prince_op_sequencer.sv
// Directed bench for prince_op_sequencer at SBOX_STAGES=4 and SBOX_STAGES=1.
module tb_prince_op_sequencer;

    logic clk;
    logic rst4;
    logic rst1;

    prince_op_sequencer_if if4();
    prince_op_sequencer_if if1();

    prince_op_sequencer #(.SBOX_STAGES(4)) dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (if4.slave)
    );

    prince_op_sequencer #(.SBOX_STAGES(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {in_ready,out_valid,load_sel,state_en,rnd_en,mid_sel,inv_sel,last_sel,busy,round,stage}
    logic [16:0] v4;
    logic [16:0] v1;
    assign v4 = {if4.in_ready, if4.out_valid, if4.load_sel, if4.state_en, if4.rnd_en,
                 if4.mid_sel, if4.inv_sel, if4.last_sel, if4.busy, if4.round, if4.stage};
    assign v1 = {if1.in_ready, if1.out_valid, if1.load_sel, if1.state_en, if1.rnd_en,
                 if1.mid_sel, if1.inv_sel, if1.last_sel, if1.busy, if1.round, if1.stage};

    localparam logic [16:0] RST_V  = {9'b1_0000_0000, 4'd0, 4'd0};
    localparam logic [16:0] LOAD_V = {9'b0_0110_0001, 4'd0, 4'd0};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov4(input string tag);
        int n;
        n = 0;
        while (!if4.out_valid && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(if4.out_valid), 32'd1);
    endtask

    int  len;
    int  n;
    int  rnd_cnt;
    int  last_cnt;
    int  nacc;
    int  acc_t [3];
    logic acc;
    logic ov_seen;
    logic found;

    initial begin
        rst4 = 1'b0;
        rst1 = 1'b0;
        if4.in_valid = 1'b0;
        if4.out_ready = 1'b0;
        if1.in_valid = 1'b0;
        if1.out_ready = 1'b0;

        // reset held low for three cycles
        repeat (3) tick();
        chk("rst_low_dut4", 32'(v4), 32'(RST_V));
        chk("rst_low_dut1", 32'(v1), 32'(RST_V));
        rst4 = 1'b1;
        rst1 = 1'b1;
        tick();
        chk("rst_rel_dut4", 32'(v4), 32'(RST_V));
        chk("rst_rel_dut1", 32'(v1), 32'(RST_V));

        // single operation, SBOX_STAGES=4
        if4.in_valid = 1'b1;
        if4.out_ready = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        chk("load_vec", 32'(v4), 32'(LOAD_V));
        rnd_cnt = 0;
        last_cnt = 0;
        for (int r = 1; r <= 11; r++) begin
            len = (r == 6) ? 8 : 4;
            for (int s = 0; s < len; s++) begin
                tick();
                chk($sformatf("run_round_r%0d_s%0d", r, s), 32'(if4.round), 32'(r));
                chk($sformatf("run_stage_r%0d_s%0d", r, s), 32'(if4.stage), 32'(s));
                chk($sformatf("run_inv_r%0d_s%0d", r, s), 32'(if4.inv_sel),
                    32'((r >= 7) || (r == 6 && s >= 4)));
                chk($sformatf("run_mid_r%0d_s%0d", r, s), 32'(if4.mid_sel), 32'(r == 6));
                chk($sformatf("run_last_r%0d_s%0d", r, s), 32'(if4.last_sel),
                    32'(r == 11 && s == 3));
                chk($sformatf("run_en_r%0d_s%0d", r, s), 32'({if4.state_en, if4.busy, if4.load_sel}),
                    32'(3'b110));
                if (if4.rnd_en) rnd_cnt++;
                if (if4.last_sel) last_cnt++;
            end
        end
        tick();
        chk("ov_at_49", 32'(if4.out_valid), 32'd1);
        chk("hold_outputs", 32'(v4), 32'({9'b1_1000_0000, 4'd0, 4'd0}));
        chk("rnd_en_count", 32'(rnd_cnt), 32'd48);
        chk("last_sel_pulses", 32'(last_cnt), 32'd1);
        tick();
        chk("idle_after_consume", 32'(v4), 32'(RST_V));

        // back-pressure in HOLD
        if4.out_ready = 1'b0;
        if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        wait_ov4("bp_reach_hold");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold_%0d", i),
                32'({if4.out_valid, if4.state_en, if4.rnd_en, if4.in_ready}), 32'(4'b1000));
            tick();
        end
        chk("bp_still_hold", 32'(if4.out_valid), 32'd1);
        if4.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_follows", 32'(if4.in_ready), 32'd1);
        tick();
        chk("bp_idle_after", 32'(v4), 32'(RST_V));

        // back-to-back operations
        if4.in_valid = 1'b1;
        if4.out_ready = 1'b1;
        nacc = 0;
        for (int c = 0; c < 400 && nacc < 3; c++) begin
            acc = if4.in_valid && if4.in_ready;
            tick();
            if (acc) begin
                acc_t[nacc] = c;
                nacc++;
                if (nacc == 3) if4.in_valid = 1'b0;
            end else if (nacc > 0) begin
                chk($sformatf("b2b_no_idle_c%0d", c), 32'(if4.busy | if4.out_valid), 32'd1);
            end
        end
        chk("b2b_accepts", 32'(nacc), 32'd3);
        chk("b2b_gap_1", 32'(acc_t[1] - acc_t[0]), 32'd50);
        chk("b2b_gap_2", 32'(acc_t[2] - acc_t[1]), 32'd50);
        wait_ov4("b2b_last_done");
        tick();
        chk("b2b_idle_after", 32'(v4), 32'(RST_V));

        // asynchronous reset in the middle round
        if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (if4.round == 4'd6 && if4.stage == 4'd5) found = 1'b1;
        end
        chk("mid_rst_reach_r6s5", 32'(found), 32'd1);
        rst4 = 1'b0;
        #1;
        chk("mid_rst_async_vec", 32'(v4), 32'(RST_V));
        repeat (2) tick();
        rst4 = 1'b1;
        ov_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (if4.out_valid) ov_seen = 1'b1;
        end
        chk("mid_rst_no_out_valid", 32'(ov_seen), 32'd0);
        chk("mid_rst_idle", 32'(v4), 32'(RST_V));

        // SBOX_STAGES=1 boundary
        if1.in_valid = 1'b1;
        if1.out_ready = 1'b1;
        tick();
        if1.in_valid = 1'b0;
        chk("s1_load_vec", 32'(v1), 32'(LOAD_V));
        for (n = 1; n <= 13; n++) begin
            tick();
            if (n == 5) chk("s1_n5_round", 32'({if1.round, if1.stage, if1.mid_sel}), 32'({4'd5, 4'd0, 1'b0}));
            if (n == 6) chk("s1_n6_mid_first", 32'({if1.round, if1.stage, if1.mid_sel, if1.inv_sel}),
                            32'({4'd6, 4'd0, 1'b1, 1'b0}));
            if (n == 7) chk("s1_n7_mid_second", 32'({if1.round, if1.stage, if1.mid_sel, if1.inv_sel}),
                            32'({4'd6, 4'd1, 1'b1, 1'b1}));
            if (n == 8) chk("s1_n8_round7", 32'({if1.round, if1.stage, if1.mid_sel, if1.inv_sel}),
                            32'({4'd7, 4'd0, 1'b0, 1'b1}));
            if (n == 11) chk("s1_n11_no_last", 32'({if1.round, if1.last_sel}), 32'({4'd10, 1'b0}));
            if (n == 12) chk("s1_n12_last", 32'({if1.round, if1.last_sel, if1.out_valid}),
                             32'({4'd11, 1'b1, 1'b0}));
            if (n == 13) chk("s1_n13_out_valid", 32'({if1.out_valid, if1.rnd_en, if1.busy}),
                             32'(3'b100));
        end
        tick();
        chk("s1_idle_after", 32'(v1), 32'(RST_V));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prince_op_sequencer.md
# prince_op_sequencer

Operation-level sequencer for the masked, pipelined-S-box PRINCE round datapath. It accepts one encryption per valid/ready handshake and drives the datapath's load, round, stage and half-select controls through the full 11-round schedule. It enables fresh-mask PRNG advance on every computing cycle and holds the result under output back-pressure. It sits between the host/testbench interface and the shared round datapath and owns all of the datapath's control and enable inputs.

## Interface
- SBOX_STAGES, 4, register stages per S-box layer; legal range 1..8.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  host presents a new masked plaintext/key set.
- in_ready  out  1  sequencer accepts the request this cycle.
- out_valid  out  1  datapath state holds a finished ciphertext.
- out_ready  in  1  host consumes the result.
- load_sel  out  1  datapath state register selects the input (whitening) path.
- state_en  out  1  datapath state/pipeline registers update.
- rnd_en  out  1  PRNG advances and delivers fresh masks.
- round  out  4  current round, 1..11; 0 outside RUN.
- stage  out  4  S-box pipeline stage within the round; 0 outside RUN.
- mid_sel  out  1  middle round (round==6) active.
- inv_sel  out  1  inverse half active: round>=7, or round==6 with stage>=SBOX_STAGES.
- last_sel  out  1  final cycle: round==11 and stage==SBOX_STAGES-1; selects output whitening.
- busy  out  1  state is LOAD or RUN.

## Operation
- FSM states: IDLE, LOAD, RUN, HOLD. Reset forces IDLE.
- Round schedule:
  - Rounds 1–5 and 7–11: SBOX_STAGES cycles each, stage 0..SBOX_STAGES-1.
  - Round 6 (middle): 2*SBOX_STAGES cycles, stage 0..2*SBOX_STAGES-1.
  - Total RUN length: 12*SBOX_STAGES cycles.
- IDLE: in_ready=1. On in_valid go to LOAD; otherwise stay.
- LOAD (1 cycle): load_sel=1, state_en=1, busy=1, round=0. Next state is RUN with round=1, stage=0.
- RUN: state_en=1, rnd_en=1, busy=1.
  - stage increments each cycle.
  - At the last stage of the round, stage returns to 0 and round increments.
  - After the last_sel cycle, go to HOLD.
- HOLD: out_valid=1, state_en=0, rnd_en=0, so the datapath result is frozen. in_ready=out_ready.
  - out_ready with in_valid: go to LOAD (back-to-back operation).
  - out_ready without in_valid: go to IDLE.
  - No out_ready: stay in HOLD indefinitely.
- in_valid during LOAD or RUN is ignored (in_ready=0). No request is queued.
- All outputs except in_ready and out_valid decode from registered state, round and stage. Both in_ready and out_valid are combinational from state; in_ready additionally depends on out_ready.
- round and stage are 4-bit registers; they never wrap in legal configurations (max stage 15 at SBOX_STAGES=8).
- Asynchronous reset at any point, including mid-RUN, returns to IDLE immediately and aborts the operation; no out_valid is produced for it.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, load_sel=0, state_en=0, rnd_en=0, round=0, stage=0, mid_sel=0, inv_sel=0, last_sel=0, busy=0.
- Accept at clock edge E0 (in_valid && in_ready). LOAD occupies the cycle after E0. RUN occupies edges E1..E(12*SBOX_STAGES).
- out_valid rises after edge E(1+12*SBOX_STAGES): 49 cycles for SBOX_STAGES=4, 13 cycles for SBOX_STAGES=1.
- Back-to-back: when HOLD consumes and accepts on the same edge, the next LOAD follows immediately. Throughput is 1 operation per 1+12*SBOX_STAGES+1 cycles with out_ready held high.
- rnd_en is high for exactly 12*SBOX_STAGES cycles per operation.

## Test plan
- Reset, with reset low for 3 cycles, then high: all outputs match the reset values above, in_ready=1.
- Single operation, SBOX_STAGES=4, out_ready=1:
  - round sequence 1,1,1,1,2,…,5, then eight cycles of round 6 (inv_sel rising at stage 4), then 7..11.
  - last_sel is a single pulse at round 11, stage 3.
  - out_valid rises 49 cycles after accept.
  - rnd_en count is 48.
- Back-pressure: hold out_ready=0 for 10 cycles in HOLD.
  - out_valid stays 1, state_en=0, rnd_en=0, in_ready=0.
  - Raise out_ready: IDLE on the next edge.
- Back-to-back: in_valid and out_ready held at 1 for 3 operations. The HOLD→LOAD transitions produce accepts spaced exactly 50 cycles apart, with no IDLE cycle between operations.
- Mid-operation reset: assert reset at round 6, stage 5. Outputs return to reset values asynchronously, and out_valid never rises for that operation.
- Boundary SBOX_STAGES=1: round 6 lasts 2 cycles, inv_sel is high from its second cycle, and out_valid rises 13 cycles after accept.
